systolic_array_ctrl: RTL and testbench
======================================

# systolic_array_ctrl

Sequencer for the N×N weight-stationary-free (output-stationary) systolic array built from `systolic_pe` tiles. On `start` it clears the array accumulators, streams K columns of A and K rows of B from two operand buffers, and applies the diagonal skew the array needs. It holds the array enabled until the last partial product reaches PE[N-1][N-1], then pulses `done` while results are stable. It sits between the operand SRAMs and the array top level.

## Interface
Parameters:
- `N`, 4: array dimension (rows = cols), ≥2
- `DATA_W`, 16: operand width per element
- `K_W`, 8: width of K length / buffer address

Ports:
- `clk`  in  1: clock
- `rst_n`  in  1: reset, asynchronous, active-low
- `start`  in  1: request a matmul; sampled only in IDLE
- `k_len`  in  K_W: reduction depth K, sampled with `start`
- `busy`  out  1: high in every state except IDLE
- `done`  out  1: one-cycle pulse; array results valid this cycle
- `op_rd_en`  out  1: read strobe to both operand buffers
- `op_rd_addr`  out  K_W: reduction index k
- `a_rd_data`  in  N*DATA_W: A[0..N-1][k], element i at bits i*DATA_W
- `b_rd_data`  in  N*DATA_W: B[k][0..N-1], element j at bits j*DATA_W
- `a_edge`  out  N*DATA_W: skewed row inputs to array west edge
- `b_edge`  out  N*DATA_W: skewed column inputs to array north edge
- `array_en`  out  1: enable to every PE MAC
- `acc_clr`  out  1: array-level accumulator clear

## Operation
- States: IDLE, CLEAR, FEED, DRAIN, DONE.
- IDLE: `start`=1, `k_len`≠0 → latch `k_len`, go CLEAR. `start`=1, `k_len`=0 → go DONE directly (no reads, no enable, no clear). `start` in any other state ignored.
- CLEAR: 1 cycle, `acc_clr`=1, `array_en`=0 → FEED.
- FEED: k_len cycles, `op_rd_en`=1, `op_rd_addr`=0..k_len-1 (counter), `array_en`=1. After address k_len-1 → DRAIN.
- DRAIN: exactly 2N-1 cycles, `array_en`=1, `op_rd_en`=0 → DONE.
- DONE: 1 cycle, `done`=1, `array_en`=0 → IDLE.
- Buffers are synchronous: data for address issued in cycle t valid in t+1. Controller carries a valid bit alongside.
- Skew: element i of `a_edge` in cycle t+1+i equals `a_rd_data[i]` read for address issued at t. Same for `b_edge` column j. Row/column 0 is a gated pass-through of read data; row i uses i registers.
- Any edge lane without valid data drives 0. Enabled PEs accumulate 0×0, so `array_en` is held continuously through FEED and DRAIN.
- Drain length derivation: last operand reaches PE[N-1][N-1] input at (last read)+1+2(N-1). MAC result registers one cycle later → 2N-1 DRAIN cycles.

## Timing
- Reset: state IDLE; `busy`, `done`, `op_rd_en`, `array_en`, `acc_clr` = 0; `op_rd_addr`=0; all skew registers and valid bits 0, so `a_edge`/`b_edge` = 0.
- Reset asserted mid-operation: immediate return to reset values; no `done` pulse; next `start` begins a fresh job.
- Latency `start`→`done`: 1 + k_len + (2N-1) + 1 cycles after the start-sample edge (N=4, K=4: `done` in cycle 13). `k_len`=0: `done` in cycle 1.
- `busy` rises the cycle after `start` is sampled and falls the cycle after `done`. Earliest next `start` acceptance is the first IDLE cycle.
- `k_len` changes after sampling have no effect.
- Counters are K_W wide. k_len = 2^K_W-1 must complete without wrap.

## Structure
- Shared package `systolic_pkg`: state enum, `DATA_W` default, and function `drain_cycles(N)` = 2N-1. The array top level reuses the function.
- One sub-module: `skew_buffer` (parameters `N`, `DATA_W`), with lane i delaying i cycles and a valid input that zero-gates its output. It is instantiated twice, once for A and once for B.

## Test plan
- N=4, K=4, A=identity, B rows {1..4},{5..8},{9..12},{13..16} → `done` at cycle 13; array C equals B; exactly 4 `op_rd_en` cycles with addresses 0,1,2,3.
- K=1, A col {2,3,4,5}, B row {1,1,1,1} → C[i][j]=A[i]; DRAIN exactly 7 cycles; `acc_clr` high exactly 1 cycle before the first read.
- `k_len`=0 → no read, no `array_en`, no `acc_clr`; `done` the next cycle; previous C untouched.
- `start` pulsed during FEED and during DONE → ignored; single `done`. `start` on the first IDLE cycle is accepted.
- Skew check, N=4: lane i of `a_edge` carries address-0 data exactly in cycle (first read)+1+i, with 0 otherwise.
- Assert `rst_n` in the 3rd FEED cycle → all outputs 0 asynchronously. After release, a K=2 job produces correct C with no residue from the aborted job.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic array and its sequencer.
// The array top level reuses drain_cycles() to size its own pipeline.
package systolic_pkg;

    localparam int DEF_DATA_W = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_DRAIN,
        S_DONE
    } state_t;

    // Last operand crosses 2(N-1) PE hops, plus one cycle for the MAC register.
    function automatic int drain_cycles(input int n);
        return 2 * n - 1;
    endfunction

endpackage

// File: rtl/skew_buffer.sv
// Diagonal skew for one array edge: lane i is delayed i cycles.
// Lanes without valid data are forced to zero.
module skew_buffer
    import systolic_pkg::*;
#(
    parameter int N      = 4,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                valid,
    input  logic [N*DATA_W-1:0] din,
    output logic [N*DATA_W-1:0] dout
);

    assign dout[0 +: DATA_W] = valid ? din[0 +: DATA_W] : '0;

    for (genvar i = 1; i < N; i++) begin : g_lane
        logic [DATA_W-1:0] pipe [i];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int s = 0; s < i; s++) pipe[s] <= '0;
            end else begin
                pipe[0] <= valid ? din[i*DATA_W +: DATA_W] : '0;
                for (int s = 1; s < i; s++) pipe[s] <= pipe[s-1];
            end
        end

        assign dout[i*DATA_W +: DATA_W] = pipe[i-1];
    end

endmodule

// File: rtl/systolic_array_ctrl.sv
// Output-stationary systolic array sequencer: clear, feed K operand
// slices with diagonal skew, drain the wavefront, then pulse done.
module systolic_array_ctrl
    import systolic_pkg::*;
#(
    parameter int N      = 4,
    parameter int DATA_W = DEF_DATA_W,
    parameter int K_W    = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [K_W-1:0]      k_len,
    output logic                busy,
    output logic                done,
    output logic                op_rd_en,
    output logic [K_W-1:0]      op_rd_addr,
    input  logic [N*DATA_W-1:0] a_rd_data,
    input  logic [N*DATA_W-1:0] b_rd_data,
    output logic [N*DATA_W-1:0] a_edge,
    output logic [N*DATA_W-1:0] b_edge,
    output logic                array_en,
    output logic                acc_clr
);

    localparam int DRAIN_N = drain_cycles(N);
    localparam int DC_W    = $clog2(DRAIN_N + 1);

    state_t          state;
    logic [K_W-1:0]  k_last;
    logic [DC_W-1:0] drain_cnt;
    logic            rd_valid;

    // Outputs are registered from the next-state decision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            k_last     <= '0;
            drain_cnt  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            op_rd_en   <= 1'b0;
            op_rd_addr <= '0;
            array_en   <= 1'b0;
            acc_clr    <= 1'b0;
        end else begin
            done    <= 1'b0;
            acc_clr <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start && k_len != '0) begin
                        k_last  <= k_len - 1'b1;
                        state   <= S_CLEAR;
                        busy    <= 1'b1;
                        acc_clr <= 1'b1;
                    end else if (start) begin
                        state <= S_DONE;
                        busy  <= 1'b1;
                        done  <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    state      <= S_FEED;
                    op_rd_en   <= 1'b1;
                    op_rd_addr <= '0;
                    array_en   <= 1'b1;
                end
                S_FEED: begin
                    if (op_rd_addr == k_last) begin
                        state     <= S_DRAIN;
                        op_rd_en  <= 1'b0;
                        drain_cnt <= '0;
                    end else begin
                        op_rd_addr <= op_rd_addr + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt == DC_W'(DRAIN_N - 1)) begin
                        state    <= S_DONE;
                        array_en <= 1'b0;
                        done     <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Buffers answer one cycle after the read strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_valid <= 1'b0;
        else        rd_valid <= op_rd_en;
    end

    skew_buffer #(.N(N), .DATA_W(DATA_W)) u_skew_a (
        .clk   (clk),
        .rst_n (rst_n),
        .valid (rd_valid),
        .din   (a_rd_data),
        .dout  (a_edge)
    );

    skew_buffer #(.N(N), .DATA_W(DATA_W)) u_skew_b (
        .clk   (clk),
        .rst_n (rst_n),
        .valid (rd_valid),
        .din   (b_rd_data),
        .dout  (b_edge)
    );

endmodule

// File: tb/tb_systolic_array_ctrl.sv
// Bench for systolic_array_ctrl: operand buffers, a behavioural
// PE grid driven by the edges, and a scoreboard of expected C.
module tb_systolic_array_ctrl;
    import systolic_pkg::*;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int KW = 8;

    typedef bit [N*N-1:0][31:0] cmat_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic [KW-1:0] k_len = '0;
    logic          busy, done, op_rd_en, array_en, acc_clr;
    logic [KW-1:0] op_rd_addr;
    logic [N*DW-1:0] a_edge, b_edge;
    bit   [N*DW-1:0] a_rd_data, b_rd_data;

    bit [N*DW-1:0] a_mem [256];
    bit [N*DW-1:0] b_mem [256];

    bit [31:0]   acc [N][N];
    bit [DW-1:0] ar  [N][N];
    bit [DW-1:0] br  [N][N];

    int    n_chk  = 0;
    int    n_fail = 0;
    int    q_done [$];
    cmat_t q_c    [$];
    cmat_t prev_c = '0;

    systolic_array_ctrl #(.N(N), .DATA_W(DW), .K_W(KW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .k_len      (k_len),
        .busy       (busy),
        .done       (done),
        .op_rd_en   (op_rd_en),
        .op_rd_addr (op_rd_addr),
        .a_rd_data  (a_rd_data),
        .b_rd_data  (b_rd_data),
        .a_edge     (a_edge),
        .b_edge     (b_edge),
        .array_en   (array_en),
        .acc_clr    (acc_clr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (op_rd_en) begin
            a_rd_data <= a_mem[op_rd_addr];
            b_rd_data <= b_mem[op_rd_addr];
        end
    end

    function automatic bit [DW-1:0] lane(input bit [N*DW-1:0] v,
                                         input int i);
        return v[i*DW +: DW];
    endfunction

    function automatic bit [DW-1:0] a_in(input int i, input int j);
        if (j == 0) return lane(a_edge, i);
        return ar[i][j-1];
    endfunction

    function automatic bit [DW-1:0] b_in(input int i, input int j);
        if (i == 0) return lane(b_edge, j);
        return br[i-1][j];
    endfunction

    // Output-stationary PE grid: A flows east, B flows south.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) begin
                    acc[i][j] <= '0;
                    ar[i][j]  <= '0;
                    br[i][j]  <= '0;
                end
        end else if (acc_clr) begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) acc[i][j] <= '0;
        end else if (array_en) begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) begin
                    acc[i][j] <= acc[i][j]
                        + 32'(a_in(i, j)) * 32'(b_in(i, j));
                    ar[i][j] <= a_in(i, j);
                    br[i][j] <= b_in(i, j);
                end
        end
    end

    function automatic cmat_t snap();
        cmat_t c;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) c[i*N+j] = acc[i][j];
        return c;
    endfunction

    function automatic cmat_t matmul(input int k);
        cmat_t c = '0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                for (int t = 0; t < k; t++)
                    c[i*N+j] += 32'(lane(a_mem[t], i))
                              * 32'(lane(b_mem[t], j));
        return c;
    endfunction

    task automatic check(input string tag, input logic [63:0] act,
                         input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic load_rand(input int k);
        for (int t = 0; t < k; t++) begin
            a_mem[t] = {$urandom, $urandom};
            b_mem[t] = {$urandom, $urandom};
        end
    endtask

    // Starts on the current (negedge) cycle; returns on the first IDLE cycle.
    task automatic run_job(input int k, input int poke, input bit poke_done);
        int    fr = -1, rd = 0, aerr = 0, clr_n = 0, clr_c = -1;
        int    en_n = 0, dr_n = 0, sk_a = 0, sk_b = 0, done_c = -1;
        int    exp_d;
        cmat_t exp_c, got;
        exp_c = (k == 0) ? prev_c : matmul(k);
        q_c.push_back(exp_c);
        q_done.push_back((k == 0) ? 1 : k + 2 * N + 1);
        prev_c = exp_c;
        start = 1'b1;
        k_len = KW'(k);
        @(posedge clk);
        #1;
        start = 1'b0;
        k_len = KW'($urandom);
        for (int c = 1; c <= k + 2 * N + 8; c++) begin
            @(negedge clk);
            start = (c == poke);
            if (op_rd_en) begin
                if (rd == 0) fr = c;
                if (op_rd_addr != KW'(rd)) aerr++;
                rd++;
            end
            if (acc_clr) begin
                clr_n++;
                clr_c = c;
            end
            if (array_en) begin
                en_n++;
                if (!op_rd_en) dr_n++;
            end
            for (int i = 0; i < N; i++) begin
                int idx = c - fr - 1 - i;
                bit [DW-1:0] ea = '0, eb = '0;
                if (fr >= 0 && idx >= 0 && idx < k) begin
                    ea = lane(a_mem[idx], i);
                    eb = lane(b_mem[idx], i);
                end
                if (lane(a_edge, i) != ea) sk_a++;
                if (lane(b_edge, i) != eb) sk_b++;
            end
            if (done) begin
                done_c = c;
                check("busy_at_done", busy, 1);
                if (poke_done) start = 1'b1;
                break;
            end
        end
        exp_d = q_done.pop_front();
        exp_c = q_c.pop_front();
        check("done_cycle", done_c, exp_d);
        if (done_c >= 0) begin
            got = snap();
            for (int e = 0; e < N * N; e++)
                check($sformatf("c[%0d]", e), got[e], exp_c[e]);
        end
        @(negedge clk);
        start = 1'b0;
        check("busy_after", busy, 0);
        check("done_after", done, 0);
        check("rd_count", rd, k);
        check("rd_addr_errs", aerr, 0);
        check("clr_count", clr_n, (k != 0) ? 1 : 0);
        if (k != 0) check("clr_before_rd", clr_c, fr - 1);
        check("en_count", en_n, (k != 0) ? k + 2 * N - 1 : 0);
        check("drain_len", dr_n, (k != 0) ? drain_cycles(N) : 0);
        check("skew_a_errs", sk_a, 0);
        check("skew_b_errs", sk_b, 0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ctl"},
              {busy, done, op_rd_en, array_en, acc_clr}, 0);
        check({tag, "_addr"}, op_rd_addr, 0);
        check({tag, "_a_edge"}, a_edge, 0);
        check({tag, "_b_edge"}, b_edge, 0);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // identity A, B rows 1..16: C == B
        for (int t = 0; t < N; t++)
            for (int i = 0; i < N; i++) begin
                a_mem[t][i*DW +: DW] = (i == t) ? DW'(1) : DW'(0);
                b_mem[t][i*DW +: DW] = DW'(t * N + i + 1);
            end
        run_job(4, -1, 1'b0);
        check("c_eq_b_11", acc[1][1], 6);
        check("c_eq_b_33", acc[3][3], 16);

        for (int i = 0; i < N; i++) begin
            a_mem[0][i*DW +: DW] = DW'(i + 2);
            b_mem[0][i*DW +: DW] = DW'(1);
        end
        run_job(1, -1, 1'b0);
        check("c_eq_a_23", acc[2][3], 4);

        run_job(0, -1, 1'b0);

        load_rand(3);
        run_job(3, 3, 1'b1);
        load_rand(2);
        run_job(2, -1, 1'b0);

        // abort in the third FEED cycle
        load_rand(5);
        start = 1'b1;
        k_len = KW'(5);
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("abort_in_feed", op_rd_en, 1);
        #1 rst_n = 1'b0;
        #1;
        check_idle_outputs("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_idle_outputs("post_rst");
        load_rand(2);
        run_job(2, -1, 1'b0);

        load_rand(255);
        run_job(255, -1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
